// File: rtl/spi_master_axis_ingress.sv
// SPI master receiver: clocks a requested number of bytes out of an SPI slave and
// delivers them on an 8-bit AXI-Stream master port, stalling SCLK under back-pressure.
module spi_master_axis_ingress #(
    parameter int          MSB_FIRST   = 1,
    parameter int          MISO_SIZE   = 1,
    parameter int          CLK_DIV     = 2,
    parameter int          FILTER_IDLE = 1,
    parameter logic [7:0]  IDLE_BYTE   = 8'hBC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          byte_count,
    output logic                 busy,
    output logic                 done,
    output logic                 spi_csn,
    output logic                 spi_clk,
    input  logic [MISO_SIZE-1:0] spi_miso,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  BIT_LAST = 3'((8 / MISO_SIZE) - 1);

    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        done_q, done_d;
    logic [7:0]  sr_shift;
    logic        div_last;
    logic        accept;

    if (MSB_FIRST != 0) begin : g_msb_first
        assign sr_shift = {sr_q[7-MISO_SIZE:0], spi_miso};
    end else begin : g_lsb_first
        assign sr_shift = {spi_miso, sr_q[7:MISO_SIZE]};
    end

    assign div_last = (div_cnt_q == DIV_LAST);
    // AXIS handshake: a beat transfers on any edge where tvalid && tready; tvalid,
    // once raised, holds with tdata unchanged until that edge, and never waits on tready.
    assign accept   = tvalid_q && m_axis_tready;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q + 16'd1;
        bit_cnt_d    = bit_cnt_q;
        bytes_left_d = bytes_left_q;
        sr_d         = sr_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        done_d       = 1'b0;
        if (accept) begin
            tvalid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                div_cnt_d = 16'd0;
                if (start && byte_count != 16'd0) begin
                    bytes_left_d = byte_count;
                    bit_cnt_d    = 3'd0;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    div_cnt_d = 16'd0;
                    state_d   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (div_last) begin
                    div_cnt_d = 16'd0;
                    sr_d      = sr_shift;
                    state_d   = ST_LOW;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d    = 3'd0;
                        bytes_left_d = bytes_left_q - 16'd1;
                        if (!(FILTER_IDLE != 0 && sr_shift == IDLE_BYTE)) begin
                            tdata_d  = sr_shift;
                            tvalid_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_LOW: begin
                if (div_last) begin
                    div_cnt_d = 16'd0;
                    if (bit_cnt_q != 3'd0) begin
                        state_d = ST_HIGH;
                    end else if (bytes_left_q != 16'd0) begin
                        // A new byte only starts once the output register is free.
                        state_d = (!tvalid_q || accept) ? ST_HIGH : ST_HOLD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                div_cnt_d = 16'd0;
                if (accept) begin
                    state_d = ST_HIGH;
                end
            end
            ST_DONE: begin
                if (div_last) begin
                    div_cnt_d = 16'd0;
                    done_d    = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (div_last) begin
                    div_cnt_d = 16'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                div_cnt_d = 16'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= 16'd0;
            bit_cnt_q    <= 3'd0;
            bytes_left_q <= 16'd0;
            sr_q         <= 8'd0;
            tdata_q      <= 8'd0;
            tvalid_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bytes_left_q <= bytes_left_d;
            sr_q         <= sr_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            done_q       <= done_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign spi_csn       = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign spi_clk       = (state_q == ST_HIGH);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_master_axis_ingress.sv
// Bench for spi_master_axis_ingress: instance A is 1-line MSB-first with idle filtering,
// instance B is 2-line LSB-first without filtering; both at CLK_DIV=2.
module tb_spi_master_axis_ingress;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] bc_a = 16'd0, bc_b = 16'd0;
    logic        busy_a, busy_b, done_a, done_b;
    logic        csn_a, csn_b, sclk_a, sclk_b;
    logic        miso_a = 1'b0;
    logic [1:0]  miso_b = 2'b00;
    logic [7:0]  tdata_a, tdata_b;
    logic        tvalid_a, tvalid_b;
    logic        tready_a = 1'b1, tready_b = 1'b1;
    logic [2:0]  dbg_a, dbg_b;

    spi_master_axis_ingress #(.MSB_FIRST(1), .MISO_SIZE(1), .CLK_DIV(2), .FILTER_IDLE(1),
                              .IDLE_BYTE(8'hBC)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .byte_count(bc_a), .busy(busy_a),
        .done(done_a), .spi_csn(csn_a), .spi_clk(sclk_a), .spi_miso(miso_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a),
        .dbg_state(dbg_a));

    spi_master_axis_ingress #(.MSB_FIRST(0), .MISO_SIZE(2), .CLK_DIV(2), .FILTER_IDLE(0),
                              .IDLE_BYTE(8'hBC)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .byte_count(bc_b), .busy(busy_b),
        .done(done_b), .spi_csn(csn_b), .spi_clk(sclk_b), .spi_miso(miso_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .dbg_state(dbg_b));

    // Slave models: shift out the next bit(s) on each SCLK rise, restart on CSN high.
    logic [7:0] slv_q_a[$];
    logic [7:0] slv_q_b[$];
    logic [7:0] cur_a = 8'hBC, cur_b = 8'hBC;
    int         idx_a = 0, idx_b = 0;

    always @(posedge sclk_a or posedge csn_a) begin
        if (csn_a) idx_a = 0;
        else begin
            if (idx_a == 0) cur_a = (slv_q_a.size() > 0) ? slv_q_a.pop_front() : 8'hBC;
            miso_a = cur_a[7 - idx_a];
            idx_a  = (idx_a + 1) % 8;
        end
    end

    always @(posedge sclk_b or posedge csn_b) begin
        if (csn_b) idx_b = 0;
        else begin
            if (idx_b == 0) cur_b = (slv_q_b.size() > 0) ? slv_q_b.pop_front() : 8'hBC;
            miso_b = {cur_b[2*idx_b+1], cur_b[2*idx_b]};
            idx_b  = (idx_b + 1) % 4;
        end
    end

    // Monitors sample on the falling edge of clk.
    int         rises_a = 0, rises_b = 0, csn_low_a = 0, csn_low_b = 0;
    int         done_cnt_a = 0, done_cnt_b = 0;
    logic       prev_a = 1'b0, prev_b = 1'b0;
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];

    always @(negedge clk) begin
        if (!csn_a) csn_low_a++;
        if (!csn_b) csn_low_b++;
        if (sclk_a && !prev_a) rises_a++;
        if (sclk_b && !prev_b) rises_b++;
        prev_a = sclk_a;
        prev_b = sclk_b;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (tvalid_a && tready_a) got_a.push_back(tdata_a);
        if (tvalid_b && tready_b) got_b.push_back(tdata_b);
    end

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        rises_a = 0; rises_b = 0; csn_low_a = 0; csn_low_b = 0;
        done_cnt_a = 0; done_cnt_b = 0;
        got_a.delete(); got_b.delete(); exp_q.delete();
    endtask

    task automatic start_xfer(input int inst, input logic [15:0] cnt);
        @(posedge clk); #1;
        if (inst == 0) begin start_a = 1'b1; bc_a = cnt; end
        else begin start_b = 1'b1; bc_b = cnt; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!(inst == 0 ? busy_a : busy_b)) begin ok = 1'b1; break; end
        end
        check({name, " idle timeout"}, {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_beats(input int inst, input string name);
        logic [7:0] e, g;
        check({name, " beat count"}, (inst == 0) ? got_a.size() : got_b.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (inst == 0 && got_a.size() > 0) g = got_a.pop_front();
            if (inst == 1 && got_b.size() > 0) g = got_b.pop_front();
            check({name, " beat"}, {24'd0, g}, {24'd0, e});
        end
    endtask

    typedef struct {
        int          inst;
        logic [15:0] count;
        logic [7:0]  tx [4];
        int          n_exp;
        logic [7:0]  exp [4];
        int          rises;
        int          csn_low;
    } vec_t;

    vec_t vecs[6];

    task automatic run_row(input vec_t v, input string name);
        clear_mon();
        tready_a = 1'b1; tready_b = 1'b1;
        for (int i = 0; i < int'(v.count); i++) begin
            if (v.inst == 0) slv_q_a.push_back(v.tx[i]); else slv_q_b.push_back(v.tx[i]);
        end
        for (int i = 0; i < v.n_exp; i++) exp_q.push_back(v.exp[i]);
        start_xfer(v.inst, v.count);
        wait_idle(v.inst, name);
        check_beats(v.inst, name);
        check({name, " rises"}, (v.inst == 0) ? rises_a : rises_b, v.rises);
        check({name, " csn low"}, (v.inst == 0) ? csn_low_a : csn_low_b, v.csn_low);
        check({name, " done"}, (v.inst == 0) ? done_cnt_a : done_cnt_b, 32'd1);
    endtask

    initial begin
        vec_t       post;
        logic [7:0] held;
        logic       ok;
        int         viol;
        int         busy_seen;

        vecs[0] = '{0, 16'd2, '{8'hA5, 8'h3C, 8'h00, 8'h00}, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00}, 16, 68};
        vecs[1] = '{0, 16'd3, '{8'h11, 8'hBC, 8'h22, 8'h00}, 2, '{8'h11, 8'h22, 8'h00, 8'h00}, 24, 100};
        vecs[2] = '{0, 16'd1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8, 36};
        vecs[3] = '{0, 16'd1, '{8'hBC, 8'h00, 8'h00, 8'h00}, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 8, 36};
        vecs[4] = '{1, 16'd1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 4, 20};
        vecs[5] = '{1, 16'd2, '{8'hBC, 8'h0F, 8'h00, 8'h00}, 2, '{8'hBC, 8'h0F, 8'h00, 8'h00}, 8, 36};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset csn_a", {31'd0, csn_a}, 32'd1);
        check("reset sclk_a", {31'd0, sclk_a}, 32'd0);
        check("reset busy_a", {31'd0, busy_a}, 32'd0);
        check("reset done_a", {31'd0, done_a}, 32'd0);
        check("reset tvalid_a", {31'd0, tvalid_a}, 32'd0);
        check("reset tdata_a", {24'd0, tdata_a}, 32'd0);
        check("reset state_a", {29'd0, dbg_a}, 32'd0);
        check("reset csn_b", {31'd0, csn_b}, 32'd1);
        check("reset tvalid_b", {31'd0, tvalid_b}, 32'd0);
        check("reset state_b", {29'd0, dbg_b}, 32'd0);

        for (int r = 0; r < 6; r++) run_row(vecs[r], $sformatf("row%0d", r));

        // First-edge latency, and a second start while busy is ignored.
        clear_mon();
        slv_q_a.push_back(8'h55);
        exp_q.push_back(8'h55);
        @(posedge clk); #1 start_a = 1'b1; bc_a = 16'd1;
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk); check("lat csn low cycle1", {31'd0, csn_a}, 32'd0);
        @(negedge clk); check("lat sclk low cycle2", {31'd0, sclk_a}, 32'd0);
        @(negedge clk); check("lat sclk high cycle3", {31'd0, sclk_a}, 32'd1);
        @(posedge clk); #1 start_a = 1'b1; bc_a = 16'd5;
        @(posedge clk); #1 start_a = 1'b0;
        wait_idle(0, "busy start");
        check_beats(0, "busy start");
        check("busy start rises", rises_a, 32'd8);
        check("busy start csn low", csn_low_a, 32'd36);

        // Zero-length start.
        clear_mon();
        busy_seen = 0;
        start_xfer(0, 16'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) busy_seen++;
        end
        check("zero start csn low", csn_low_a, 32'd0);
        check("zero start busy", busy_seen, 32'd0);

        // Back-pressure after the first byte.
        clear_mon();
        tready_a = 1'b1;
        slv_q_a.push_back(8'h01); slv_q_a.push_back(8'h82); slv_q_a.push_back(8'h7E);
        exp_q.push_back(8'h01); exp_q.push_back(8'h82); exp_q.push_back(8'h7E);
        start_xfer(0, 16'd3);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tvalid_a) begin ok = 1'b1; break; end
        end
        check("bp first beat timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1 tready_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tvalid_a) begin ok = 1'b1; break; end
        end
        check("bp second beat timeout", {31'd0, ok}, 32'd1);
        held = tdata_a;
        check("bp held byte", {24'd0, held}, 32'h82);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sclk_a || !tvalid_a || tdata_a !== held) viol++;
        end
        check("bp stall violations", viol, 32'd0);
        @(posedge clk); #1 tready_a = 1'b1;
        @(negedge clk); check("bp sclk before accept", {31'd0, sclk_a}, 32'd0);
        @(negedge clk); check("bp sclk resume", {31'd0, sclk_a}, 32'd1);
        wait_idle(0, "bp");
        check_beats(0, "bp");
        check("bp rises", rises_a, 32'd24);
        check("bp done", done_cnt_a, 32'd1);

        // Reset in the middle of a byte.
        clear_mon();
        slv_q_a.push_back(8'hC3); slv_q_a.push_back(8'h99);
        start_xfer(0, 16'd2);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (rises_a >= 3) begin ok = 1'b1; break; end
        end
        check("rst mid timeout", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst mid csn", {31'd0, csn_a}, 32'd1);
        check("rst mid sclk", {31'd0, sclk_a}, 32'd0);
        check("rst mid tvalid", {31'd0, tvalid_a}, 32'd0);
        check("rst mid busy", {31'd0, busy_a}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        slv_q_a.delete();
        post = '{0, 16'd1, '{8'h6D, 8'h00, 8'h00, 8'h00}, 1, '{8'h6D, 8'h00, 8'h00, 8'h00}, 8, 36};
        run_row(post, "post rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
